// File: rtl/beep_sched.sv
// beep_sched: priority buzzer scheduler turning tick/fail/win pulses into tone patterns.
// Build option BEEP_PEND_EN: queue lower-priority requests in a 3-bit pending register.
module beep_sched #(
  parameter int TONE_DIV = 500,
  parameter int UNIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] req,
  output logic       beep,
  output logic       busy,
  output logic [1:0] cur,
  output logic       over
);
  localparam int UW = $clog2(UNIT_CYC);
  localparam int TW = $clog2(2 * TONE_DIV + 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state, state_n;
  logic [1:0]    src;
  logic [2:0]    seg;
  logic          seg_u;
  logic [UW-1:0] unit_cnt;
  logic [TW-1:0] tone_cnt;
  logic [2:0]    pend;
  logic [2:0]    avail;
  logic          load;
  logic [1:0]    load_id;
  logic          unit_end;
  logic          pat_end;

  function automatic logic [1:0] top_id(input logic [2:0] v);
    if (v[2])      return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [TW-1:0] half_per(input logic [1:0] id);
    case (id)
      2'd1:    return TW'(2 * TONE_DIV);
      2'd2:    return TW'(TONE_DIV / 2);
      default: return TW'(TONE_DIV);
    endcase
  endfunction

  // win alternates ON/OFF; odd segments are silent
  function automatic logic seg_on(input logic [1:0] id, input logic [2:0] s);
    return (id != 2'd2) || !s[0];
  endfunction

  function automatic logic seg_long(input logic [1:0] id, input logic [2:0] s);
    return (id == 2'd1) || (id == 2'd2 && s == 3'd4);
  endfunction

  function automatic logic [2:0] last_seg(input logic [1:0] id);
    return (id == 2'd2) ? 3'd4 : 3'd0;
  endfunction

  assign avail    = req | pend;
  assign unit_end = unit_cnt == UW'(UNIT_CYC - 1);
  assign pat_end  = unit_end && (seg_u == seg_long(src, seg))
                 && (seg == last_seg(src));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    load_id = src;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        PLAY: begin
          if (|req && top_id(req) >= src) begin
            load    = 1'b1;
            load_id = top_id(req);
          end else if (pat_end) begin
            state_n = DONE;
          end
        end
        default: begin
          state_n = IDLE;
          if (|avail) begin
            load    = 1'b1;
            load_id = top_id(avail);
            state_n = PLAY;
          end
        end
      endcase
    end
  end

`ifdef BEEP_PEND_EN
  logic [2:0] pend_q;
  logic [2:0] load_mask;

  assign load_mask = load ? (3'b001 << load_id) : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) pend_q <= 3'b000;
    else               pend_q <= (pend_q | req) & ~load_mask;
  end

  assign pend = pend_q;
`else
  assign pend = 3'b000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src      <= 2'd0;
      seg      <= 3'd0;
      seg_u    <= 1'b0;
      unit_cnt <= '0;
      tone_cnt <= '0;
      beep     <= 1'b0;
    end else if (load) begin
      src      <= load_id;
      seg      <= 3'd0;
      seg_u    <= 1'b0;
      unit_cnt <= '0;
      tone_cnt <= '0;
      beep     <= 1'b1;
    end else if (state == PLAY && en) begin
      if (seg_on(src, seg)) begin
        if (tone_cnt == half_per(src) - TW'(1)) begin
          tone_cnt <= '0;
          beep     <= ~beep;
        end else begin
          tone_cnt <= tone_cnt + TW'(1);
        end
      end
      // segment boundaries override the tone toggle above
      if (unit_end) begin
        unit_cnt <= '0;
        if (seg_u != seg_long(src, seg)) begin
          seg_u <= 1'b1;
        end else if (seg != last_seg(src)) begin
          seg      <= seg + 3'd1;
          seg_u    <= 1'b0;
          tone_cnt <= '0;
          beep     <= seg_on(src, seg + 3'd1);
        end else begin
          beep <= 1'b0;
        end
      end else begin
        unit_cnt <= unit_cnt + UW'(1);
      end
    end else begin
      seg      <= 3'd0;
      seg_u    <= 1'b0;
      unit_cnt <= '0;
      tone_cnt <= '0;
      beep     <= 1'b0;
    end
  end

  assign busy = state == PLAY;
  assign over = state == DONE;
  assign cur  = busy ? src : 2'd3;

endmodule
